regfile_write_scheduler: RTL and testbench

Sequences the register file's single write port among several writeback sources (ALU, load unit, loader/debug) using round-robin valid/ready arbitration. It also keeps a pending-write scoreboard so issue logic can stall on read-after-write hazards against rs/rt. The block sits between the writeback stages and the register file. It drives the file's registerWrite, writeAddress and writeData inputs from registered outputs.

---
 rtl/regfile_write_scheduler.sv | 142 ++++++++++++++
 tb/tb_regfile_write_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
//
// Shares the register file's single write port among NUM_REQ writeback
// sources (0 = ALU, 1 = load unit, 2 = loader/debug) with round-robin
// valid/ready arbitration. It also keeps a pending-write scoreboard so that
// issue logic can stall on read-after-write hazards against rs/rt.
//
// Ports
//   clk                     rising-edge clock
//   rst                     asynchronous, active-low reset
//   req_valid[NUM_REQ]      per-requester write request
//   req_addr / req_data     packed per-requester address/data (requester i at
//                           [i*W +: W])
//   req_ready[NUM_REQ]      one-hot grant, combinational from req_valid and ptr
//   pend_set, pend_addr     mark a destination register as awaiting writeback
//   rs_addr, rt_addr        source registers under hazard check
//   hazard                  rs or rt has a pending write (combinational)
//   registerWrite           register file write enable (registered)
//   writeAddress            register file write address (registered)
//   writeData               register file write data (registered)
module regfile_write_scheduler #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            pend_set,
  input  logic [ADDR_WIDTH-1:0]           pend_addr,
  input  logic [ADDR_WIDTH-1:0]           rs_addr,
  input  logic [ADDR_WIDTH-1:0]           rt_addr,
  output logic                            hazard,
  output logic                            registerWrite,
  output logic [ADDR_WIDTH-1:0]           writeAddress,
  output logic [DATA_WIDTH-1:0]           writeData
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int NREG  = 1 << ADDR_WIDTH;

  logic [PTR_W-1:0]      ptr_q;
  logic [NREG-1:0]       pending_q;
  logic [NREG-1:0]       pending_nxt;

  logic                  vld_p0;
  logic [PTR_W-1:0]      gnt_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] data_p0;

  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] g);
    if (g == PTR_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return g + 1'b1;
  endfunction

  // ---- Stage p0: round-robin grant ----
  // Two passes replace a modulo scan: requesters at or above ptr first, then
  // the ones below it. The first valid one found wins.
  always_comb begin
    req_ready = '0;
    vld_p0    = 1'b0;
    gnt_p0    = '0;
    addr_p0   = '0;
    data_p0   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!vld_p0 && (i >= int'(ptr_q)) && req_valid[i]) begin
        vld_p0       = 1'b1;
        gnt_p0       = PTR_W'(i);
        req_ready[i] = 1'b1;
        addr_p0      = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        data_p0      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!vld_p0 && (i < int'(ptr_q)) && req_valid[i]) begin
        vld_p0       = 1'b1;
        gnt_p0       = PTR_W'(i);
        req_ready[i] = 1'b1;
        addr_p0      = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        data_p0      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ---- Stage p1: registered write port and pointer update ----
  // A transfer to register 0 is still consumed (pointer advances), but the
  // write enable stays low since register 0 is hardwired to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else if (vld_p0) begin
      ptr_q   <= next_ptr(gnt_p0);
      vld_p1  <= (addr_p0 != '0);
      addr_p1 <= addr_p0;
      data_p1 <= data_p0;
    end else begin
      vld_p1  <= 1'b0;
    end
  end

  assign registerWrite = vld_p1;
  assign writeAddress  = addr_p1;
  assign writeData     = data_p1;

  // Scoreboard: the clear from the write being presented is applied first so
  // that a same-cycle set to that register wins (the new producer is still
  // outstanding). Bit 0 is forced low.
  always_comb begin
    pending_nxt = pending_q;
    if (vld_p1) begin
      pending_nxt[addr_p1] = 1'b0;
    end
    if (pend_set && (pend_addr != '0)) begin
      pending_nxt[pend_addr] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_nxt;
    end
  end

  assign hazard = ((rs_addr != '0) && pending_q[rs_addr]) ||
                  ((rt_addr != '0) && pending_q[rt_addr]);

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler. Stimulus pushes each expected
// register-file write (address, data, cycle of the pulse) into a queue; a
// monitor pops and compares whenever registerWrite is presented.
module tb_regfile_write_scheduler;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            pend_set;
  logic [AW-1:0]   pend_addr;
  logic [AW-1:0]   rs_addr;
  logic [AW-1:0]   rt_addr;
  logic            hazard;
  logic            registerWrite;
  logic [AW-1:0]   writeAddress;
  logic [DW-1:0]   writeData;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic [AW-1:0] rr_a [6] = '{5'd10, 5'd11, 5'd12, 5'd20, 5'd21, 5'd22};
  logic [DW-1:0] rr_d [6] = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002,
                              32'hB000_0000, 32'hB000_0001, 32'hB000_0002};

  regfile_write_scheduler #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .pend_set(pend_set), .pend_addr(pend_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .hazard(hazard),
    .registerWrite(registerWrite), .writeAddress(writeAddress),
    .writeData(writeData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // Called during the cycle the transfer is issued: the pulse lands next cycle.
  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = cyc + 1;
    q.push_back(e);
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst && registerWrite) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0d data=%0h required no write",
                 writeAddress, writeData);
      end else begin
        mon_e = q.pop_front();
        check("wr_addr", 64'(writeAddress), 64'(mon_e.addr));
        check("wr_data", 64'(writeData), 64'(mon_e.data));
        check("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    pend_set = 1'b0; pend_addr = '0; rs_addr = '0; rt_addr = '0;

    // Reset state; req_ready follows req_valid with ptr=0
    repeat (2) drive_edge();
    req_valid = 3'b111;
    @(negedge clk);
    check("rst_regwrite", 64'(registerWrite), 64'd0);
    check("rst_waddr", 64'(writeAddress), 64'd0);
    check("rst_wdata", 64'(writeData), 64'd0);
    check("rst_hazard", 64'(hazard), 64'd0);
    check("rst_ready", 64'(req_ready), 64'b001);

    // Single write from requester 1
    drive_edge();
    rst = 1'b1;
    req_valid = 3'b010;
    set_req(1, 5'd5, 32'hDEADBEEF);
    push(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    check("single_ready", 64'(req_ready), 64'b010);
    drive_edge();
    req_valid = '0;
    @(negedge clk);
    check("single_pulse", 64'(registerWrite), 64'd1);
    drive_edge();
    // Address 0 from requester 0 (ptr is 2, only 0 valid)
    req_valid = 3'b001;
    set_req(0, 5'd0, 32'h0000_1234);
    @(negedge clk);
    check("single_pulse_end", 64'(registerWrite), 64'd0);
    check("addr0_ready", 64'(req_ready), 64'b001);
    drive_edge();
    req_valid = 3'b011;
    set_req(1, 5'd6, 32'h0000_0066);
    push(5'd6, 32'h0000_0066);
    @(negedge clk);
    check("addr0_nowrite", 64'(registerWrite), 64'd0);
    check("addr0_next_grant", 64'(req_ready), 64'b010);
    drive_edge();
    req_valid = 3'b100;
    set_req(2, 5'd8, 32'h0000_0088);
    push(5'd8, 32'h0000_0088);
    @(negedge clk);
    check("req2_ready", 64'(req_ready), 64'b100);

    // Round robin: all valid for 6 cycles, grants 0,1,2,0,1,2
    for (int k = 0; k < 6; k++) begin
      drive_edge();
      if (k == 0) begin
        for (int i = 0; i < 3; i++) set_req(i, rr_a[i], rr_d[i]);
        req_valid = 3'b111;
      end else if (k <= 3) begin
        set_req(k - 1, rr_a[k + 2], rr_d[k + 2]);
      end
      push(rr_a[k], rr_d[k]);
      @(negedge clk);
      check("rr_grant", 64'(req_ready), 64'(3'b001 << (k % 3)));
    end

    // Scoreboard on register 7
    drive_edge();
    req_valid = '0;
    pend_set = 1'b1; pend_addr = 5'd7; rs_addr = 5'd7; rt_addr = 5'd0;
    @(negedge clk);
    check("haz_before_set", 64'(hazard), 64'd0);
    drive_edge();
    pend_set = 1'b0;
    @(negedge clk);
    check("haz_rs7", 64'(hazard), 64'd1);
    drive_edge();
    rs_addr = 5'd0; rt_addr = 5'd7;
    @(negedge clk);
    check("haz_rt7", 64'(hazard), 64'd1);
    drive_edge();
    rt_addr = 5'd0;
    pend_set = 1'b1; pend_addr = 5'd0;
    @(negedge clk);
    check("haz_zero_a", 64'(hazard), 64'd0);
    drive_edge();
    pend_set = 1'b0;
    @(negedge clk);
    check("haz_zero_b", 64'(hazard), 64'd0);
    drive_edge();
    rs_addr = 5'd7;
    req_valid = 3'b001;
    set_req(0, 5'd7, 32'h0000_0077);
    push(5'd7, 32'h0000_0077);
    @(negedge clk);
    check("wb7_ready", 64'(req_ready), 64'b001);
    check("haz_wb7_issue", 64'(hazard), 64'd1);
    drive_edge();
    req_valid = '0;
    @(negedge clk);
    check("haz_wb7_pulse", 64'(hazard), 64'd1);
    drive_edge();
    @(negedge clk);
    check("haz_wb7_clear", 64'(hazard), 64'd0);

    // Set/clear collision on register 9 (ptr is 1)
    drive_edge();
    pend_set = 1'b1; pend_addr = 5'd9; rs_addr = 5'd9;
    drive_edge();
    pend_set = 1'b0;
    req_valid = 3'b010;
    set_req(1, 5'd9, 32'h0000_0099);
    push(5'd9, 32'h0000_0099);
    @(negedge clk);
    check("col_ready", 64'(req_ready), 64'b010);
    check("col_haz_a", 64'(hazard), 64'd1);
    drive_edge();
    req_valid = '0;
    pend_set = 1'b1; pend_addr = 5'd9;
    @(negedge clk);
    check("col_haz_b", 64'(hazard), 64'd1);
    drive_edge();
    pend_set = 1'b0;
    @(negedge clk);
    check("col_keep", 64'(hazard), 64'd1);
    drive_edge();
    req_valid = 3'b001;
    set_req(0, 5'd9, 32'h0000_0999);
    push(5'd9, 32'h0000_0999);
    @(negedge clk);
    check("col_clear_ready", 64'(req_ready), 64'b001);
    drive_edge();
    req_valid = '0;
    drive_edge();
    @(negedge clk);
    check("col_clear", 64'(hazard), 64'd0);

    // Reset mid-operation (ptr is 1, register 12 pending)
    drive_edge();
    pend_set = 1'b1; pend_addr = 5'd12; rs_addr = 5'd12;
    drive_edge();
    pend_set = 1'b0;
    @(negedge clk);
    check("pre_rst_haz", 64'(hazard), 64'd1);
    drive_edge();
    set_req(0, 5'd1, 32'h0000_0011);
    set_req(1, 5'd2, 32'h0000_0022);
    set_req(2, 5'd3, 32'h0000_0033);
    req_valid = 3'b111;
    rst = 1'b0;
    @(negedge clk);
    check("mr_ready", 64'(req_ready), 64'b001);
    check("mr_regwrite", 64'(registerWrite), 64'd0);
    check("mr_hazard", 64'(hazard), 64'd0);
    drive_edge();
    rst = 1'b1;
    push(5'd1, 32'h0000_0011);
    @(negedge clk);
    check("mr_first_grant", 64'(req_ready), 64'b001);
    drive_edge();
    req_valid = '0;
    repeat (3) drive_edge();
    @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
